// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for the bit-serial subtractor.
//   start        request, accepted on an edge where ready = 1
//   num1, num2   minuend / subtrahend, N bits, sampled on the accepting edge
//   ready        high while the subtractor is idle
//   diff         (num1 - num2) mod 2^N, registered
//   borrow       1 iff num1 < num2, registered
//   valid        one-cycle completion pulse
// master: requester side; slave: the subtractor.
interface serial_subtractor_if #(
   parameter int unsigned N = 5
) ();

   logic         start;
   logic [N-1:0] num1;
   logic [N-1:0] num2;
   logic         ready;
   logic [N-1:0] diff;
   logic         borrow;
   logic         valid;

   modport master (
      output start, num1, num2,
      input  ready, diff, borrow, valid
   );

   modport slave (
      input  start, num1, num2,
      output ready, diff, borrow, valid
   );

endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit unsigned subtractor, LSB first, one full-subtractor
// cell and a single borrow flop. Result appears N edges after the accepting edge.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus_io  serial_subtractor_if slave port (start/num1/num2 in, ready/diff/borrow/valid out)
// The N parameter must match the N of the connected interface instance.
module serial_subtractor #(
   parameter int unsigned N = 5
) (
   input logic                 clk,
   input logic                 rst,
   serial_subtractor_if.slave  bus_io
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic            br_q, br_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    res_q, res_d;
   logic [N-1:0]    diff_q, diff_d;
   logic            borrow_q, borrow_d;

   logic            bit_d;
   logic            br_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;

      // Full-subtractor cell on the current LSBs.
      bit_d   = a_q[0] ^ b_q[0] ^ br_q;
      br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               a_d     = bus_io.num1;
               b_d     = bus_io.num2;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // Bits enter at the MSB; after N shifts bit 0 has reached position 0.
            res_d = {bit_d, res_q[N-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            if (cnt_q == LastCnt) begin
               diff_d   = {bit_d, res_q[N-1:1]};
               borrow_d = br_next;
               state_d  = StDone;
            end else begin
               // Held at N-1 on the last bit so the counter never wraps.
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus_io.ready  = (state_q == StIdle);
   assign bus_io.valid  = (state_q == StDone);
   assign bus_io.diff   = diff_q;
   assign bus_io.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: checks an N=5 and an N=8 serial_subtractor. Inputs are driven 2 time
// units after the rising edge, outputs sampled on the falling edge.
module tb_serial_subtractor;

   logic clk;
   logic rst;

   int vectors;
   int miscompares;
   int vcount5;
   int vcount8;

   serial_subtractor_if #(.N(5)) if5 ();
   serial_subtractor_if #(.N(8)) if8 ();

   serial_subtractor #(.N(5)) u_dut5 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if5.slave)
   );

   serial_subtractor #(.N(8)) u_dut8 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboards hold {borrow, diff} computed from the operands at the accepting edge.
   logic [31:0] q5[$];
   logic [31:0] q8[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q5.delete();
      end else begin
         if (if5.valid) begin
            vcount5++;
            if (q5.size() == 0) chk("n5 unexpected valid", 32'd1, 32'd0);
            else chk("n5 scoreboard", {26'd0, if5.borrow, if5.diff}, q5.pop_front());
         end
         if (if5.start && if5.ready) begin
            logic [4:0] d5;
            d5 = if5.num1 - if5.num2;
            q5.push_back({26'd0, (if5.num1 < if5.num2), d5});
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
      end else begin
         if (if8.valid) begin
            vcount8++;
            if (q8.size() == 0) chk("n8 unexpected valid", 32'd1, 32'd0);
            else chk("n8 scoreboard", {23'd0, if8.borrow, if8.diff}, q8.pop_front());
         end
         if (if8.start && if8.ready) begin
            logic [7:0] d8;
            d8 = if8.num1 - if8.num2;
            q8.push_back({23'd0, (if8.num1 < if8.num2), d8});
         end
      end
   end

   typedef struct {
      logic [4:0] n1;
      logic [4:0] n2;
      logic [4:0] exp_diff;
      logic       exp_borrow;
      string      name;
   } vec_t;

   // One N=5 operation: latency, result, single valid pulse, return to idle.
   task automatic op5(input vec_t v);
      int lat;
      int vc;
      vc = vcount5;
      @(posedge clk); #2;
      if5.start = 1'b1;
      if5.num1  = v.n1;
      if5.num2  = v.n2;
      @(negedge clk);
      chk({v.name, " ready"}, {31'd0, if5.ready}, 32'd1);
      @(posedge clk); #2;
      if5.start = 1'b0;
      if5.num1  = 5'($urandom);
      if5.num2  = 5'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!if5.valid && lat < 30);
      chk({v.name, " latency"}, lat, 32'd6);
      chk({v.name, " diff"}, {27'd0, if5.diff}, {27'd0, v.exp_diff});
      chk({v.name, " borrow"}, {31'd0, if5.borrow}, {31'd0, v.exp_borrow});
      @(negedge clk);
      chk({v.name, " valid drop"}, {31'd0, if5.valid}, 32'd0);
      chk({v.name, " ready back"}, {31'd0, if5.ready}, 32'd1);
      chk({v.name, " one pulse"}, vcount5 - vc, 32'd1);
   endtask

   task automatic op8;
      int lat;
      @(posedge clk); #2;
      if8.start = 1'b1;
      if8.num1  = 8'($urandom);
      if8.num2  = 8'($urandom);
      @(posedge clk); #2;
      if8.start = 1'b0;
      if8.num1  = 8'($urandom);
      if8.num2  = 8'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!if8.valid && lat < 30);
      if (lat != 9) chk("n8 latency", lat, 32'd9);
      @(negedge clk);
   endtask

   vec_t tbl[8];

   initial begin
      int vc;
      int prev;

      tbl[0] = '{5'd13, 5'd6,  5'd7,  1'b0, "13-6"};
      tbl[1] = '{5'd6,  5'd13, 5'd25, 1'b1, "6-13"};
      tbl[2] = '{5'd0,  5'd0,  5'd0,  1'b0, "0-0"};
      tbl[3] = '{5'd31, 5'd31, 5'd0,  1'b0, "31-31"};
      tbl[4] = '{5'd0,  5'd1,  5'd31, 1'b1, "0-1"};
      tbl[5] = '{5'd31, 5'd0,  5'd31, 1'b0, "31-0"};
      tbl[6] = '{5'd20, 5'd3,  5'd17, 1'b0, "20-3"};
      tbl[7] = '{5'd9,  5'd4,  5'd5,  1'b0, "9-4"};

      vectors     = 0;
      miscompares = 0;
      vcount5     = 0;
      vcount8     = 0;
      rst       = 1'b1;
      if5.start = 1'b0;
      if5.num1  = '0;
      if5.num2  = '0;
      if8.start = 1'b0;
      if8.num1  = '0;
      if8.num2  = '0;

      repeat (3) @(negedge clk);
      chk("reset diff",   {27'd0, if5.diff},   32'd0);
      chk("reset borrow", {31'd0, if5.borrow}, 32'd0);
      chk("reset valid",  {31'd0, if5.valid},  32'd0);
      chk("reset ready",  {31'd0, if5.ready},  32'd1);
      chk("reset ready8", {31'd0, if8.ready},  32'd1);
      @(posedge clk); #2;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) op5(tbl[i]);

      // start held high with operands changing every cycle: one accept per N+2 cycles.
      @(posedge clk); #2;
      if5.start = 1'b1;
      prev = -1;
      for (int c = 0; c < 30; c++) begin
         if5.num1 = 5'($urandom);
         if5.num2 = 5'($urandom);
         @(negedge clk);
         if (if5.ready) begin
            if (prev >= 0) chk("held spacing", c - prev, 32'd7);
            prev = c;
         end
         @(posedge clk); #2;
      end
      if5.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("held drained", q5.size(), 32'd0);

      // start pulsed with 1-2 during RUN and DONE of 20-3.
      vc = vcount5;
      @(posedge clk); #2;
      if5.start = 1'b1;
      if5.num1  = 5'd20;
      if5.num2  = 5'd3;
      @(posedge clk); #2;
      if5.num1 = 5'd1;
      if5.num2 = 5'd2;
      begin
         int lat;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!if5.valid && lat < 30);
         chk("ignore lat", lat, 32'd6);
      end
      @(posedge clk); #2;
      if5.start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (!if5.ready) chk("ignore no restart", {31'd0, if5.ready}, 32'd1);
      end
      chk("ignore diff",   {27'd0, if5.diff},   32'd17);
      chk("ignore borrow", {31'd0, if5.borrow}, 32'd0);
      chk("ignore pulses", vcount5 - vc, 32'd1);

      // Asynchronous reset after two bit edges of 9-4.
      @(posedge clk); #2;
      if5.start = 1'b1;
      if5.num1  = 5'd9;
      if5.num2  = 5'd4;
      @(posedge clk); #2;
      if5.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrun diff",   {27'd0, if5.diff},   32'd0);
      chk("midrun borrow", {31'd0, if5.borrow}, 32'd0);
      chk("midrun valid",  {31'd0, if5.valid},  32'd0);
      chk("midrun ready",  {31'd0, if5.ready},  32'd1);
      vc = vcount5;
      repeat (3) @(negedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrun no pulse", vcount5 - vc, 32'd0);
      op5(tbl[7]);

      // N=8 random operations against the scoreboard model.
      for (int i = 0; i < 1000; i++) op8();
      repeat (4) @(negedge clk);
      chk("n8 op count", vcount8, 32'd1000);
      chk("n8 drained", q8.size(), 32'd0);
      chk("n5 drained", q5.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
